// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types, opcodes and decode helpers for the memory stage
package mem_stage_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;
    localparam int BE_W      = NUM_LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_cause_e;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instruction_s;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] FN_ADDU    = 6'h21;

    function automatic logic k_lw(instruction_s i);
        return i.opcode == OP_LW;
    endfunction

    function automatic logic k_lbu(instruction_s i);
        return i.opcode == OP_LBU;
    endfunction

    function automatic logic k_sw(instruction_s i);
        return i.opcode == OP_SW;
    endfunction

    function automatic logic k_sb(instruction_s i);
        return i.opcode == OP_SB;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// rtl/mem_stage_lsu_align.sv - little-endian byte-enable generation, store replication and LBU extraction
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic              byte_op,
    input  logic [LANE_W-1:0] lane,
    input  logic [31:0]       store_data,
    output logic [BE_W-1:0]   be,
    output logic [31:0]       store_word,
    input  logic              load_byte,
    input  logic [LANE_W-1:0] load_lane,
    input  logic [31:0]       load_word,
    output logic [31:0]       load_result
);

    always_comb begin
        be          = '1;
        store_word  = store_data;
        load_result = load_word;
        if (byte_op) begin
            be         = {{(BE_W-1){1'b0}}, 1'b1} << lane;
            store_word = {NUM_LANES{store_data[7:0]}};
        end
        if (load_byte) begin
            load_result = {24'b0, load_word[8*load_lane +: 8]};
        end
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: request FSM, byte steering, timeout and registered writeback
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         valid_i,
    input  instruction_s op_i,
    input  logic [31:0]  alu_result_i,
    input  logic [31:0]  wdata_i,
    input  logic         wb_en_i,
    input  logic [4:0]   wb_idx_i,
    output logic         stall_o,
    output logic         wb_valid_o,
    output logic [4:0]   wb_idx_o,
    output logic [31:0]  wb_data_o,
    output logic         mem_req_valid_o,
    input  logic         mem_req_ready_i,
    output logic         mem_we_o,
    output logic [29:0]  mem_addr_o,
    output logic [3:0]   mem_be_o,
    output logic [31:0]  mem_wdata_o,
    input  logic         mem_rsp_valid_i,
    input  logic [31:0]  mem_rsp_data_i,
    output logic         err_o,
    output err_cause_e   err_cause_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    mem_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q;

    logic              req_we_q;
    logic [29:0]       req_addr_q;
    logic [BE_W-1:0]   req_be_q;
    logic [31:0]       req_wdata_q;
    logic [LANE_W-1:0] lane_q;
    logic              lbu_q;
    logic              ld_wb_en_q;
    logic [4:0]        ld_idx_q;

    logic              wb_valid_q;
    logic [4:0]        wb_idx_q;
    logic [31:0]       wb_data_q;
    logic              err_q;
    err_cause_e        err_cause_q;

    logic op_lw, op_lbu, op_sw, op_sb, op_mem, misaligned;
    logic accept_pass, accept_misalign, accept_mem, load_done, timeout_hit, tmo_reached;
    logic [BE_W-1:0] align_be;
    logic [31:0]     align_wdata;
    logic [31:0]     load_result;
    logic            unused_op;

    assign op_lw      = k_lw(op_i);
    assign op_lbu     = k_lbu(op_i);
    assign op_sw      = k_sw(op_i);
    assign op_sb      = k_sb(op_i);
    assign op_mem     = op_lw | op_lbu | op_sw | op_sb;
    assign misaligned = (op_lw | op_sw) && (alu_result_i[1:0] != 2'b00);
    assign unused_op  = ^{op_i.rs, op_i.rt, op_i.rd, op_i.shamt, op_i.funct};

    // A zero TIMEOUT never reaches the limit, so accesses wait forever.
    assign tmo_reached = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    lsu_align u_lsu_align (
        .byte_op     (op_sb | op_lbu),
        .lane        (alu_result_i[1:0]),
        .store_data  (wdata_i),
        .be          (align_be),
        .store_word  (align_wdata),
        .load_byte   (lbu_q),
        .load_lane   (lane_q),
        .load_word   (mem_rsp_data_i),
        .load_result (load_result)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake and response are tested before the timeout so they win a tie.
    always_comb begin
        state_d         = state_q;
        accept_pass     = 1'b0;
        accept_misalign = 1'b0;
        accept_mem      = 1'b0;
        load_done       = 1'b0;
        timeout_hit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (!op_mem) begin
                        accept_pass = wb_en_i;
                    end else if (misaligned) begin
                        accept_misalign = 1'b1;
                    end else begin
                        accept_mem = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready_i) begin
                    state_d = req_we_q ? IDLE : WAIT;
                end else if (tmo_reached) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    load_done = 1'b1;
                    state_d   = IDLE;
                end else if (tmo_reached) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else if (accept_mem) begin
            cnt_q <= '0;
        end else if (state_q != IDLE) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            lane_q      <= '0;
            lbu_q       <= 1'b0;
            ld_wb_en_q  <= 1'b0;
            ld_idx_q    <= '0;
        end else if (accept_mem) begin
            req_we_q    <= op_sw | op_sb;
            req_addr_q  <= alu_result_i[31:2];
            req_be_q    <= align_be;
            req_wdata_q <= align_wdata;
            lane_q      <= alu_result_i[1:0];
            lbu_q       <= op_lbu;
            ld_wb_en_q  <= wb_en_i;
            ld_idx_q    <= wb_idx_i;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wb_valid_q  <= 1'b0;
            wb_idx_q    <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            err_cause_q <= ERR_NONE;
        end else begin
            wb_valid_q  <= accept_pass | (load_done & ld_wb_en_q);
            err_q       <= accept_misalign | timeout_hit;
            err_cause_q <= accept_misalign ? ERR_MISALIGN :
                           timeout_hit     ? ERR_TIMEOUT  : ERR_NONE;
            if (accept_pass) begin
                wb_idx_q  <= wb_idx_i;
                wb_data_q <= alu_result_i;
            end else if (load_done && ld_wb_en_q) begin
                wb_idx_q  <= ld_idx_q;
                wb_data_q <= load_result;
            end
        end
    end

    assign stall_o         = (state_q != IDLE);
    assign mem_req_valid_o = (state_q == REQ);
    assign mem_we_o        = req_we_q;
    assign mem_addr_o      = req_addr_q;
    assign mem_be_o        = req_be_q;
    assign mem_wdata_o     = req_wdata_q;
    assign wb_valid_o      = wb_valid_q;
    assign wb_idx_o        = wb_idx_q;
    assign wb_data_o       = wb_data_q;
    assign err_o           = err_q;
    assign err_cause_o     = err_cause_q;

endmodule
